// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock parametrised FIFO with occupancy count, threshold flags, sticky errors and optional FWFT read
module sync_fifo_param #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = 12,
    parameter int AE_THRESH = 2,
    parameter int FWFT      = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       rd_en,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       rd_valid,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic                       overflow,
    output logic                       underflow,
    input  logic                       clr_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              overflow_q, overflow_d, underflow_q, underflow_d;
    logic              wr_acc, rd_acc;

    assign count        = count_q;
    assign full         = count_q == CW'(DEPTH);
    assign empty        = count_q == '0;
    assign almost_full  = count_q >= CW'(AF_THRESH);
    assign almost_empty = count_q <= CW'(AE_THRESH);
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    // Accept operations against registered full/empty; a rejected op touches nothing but its error flag
    always_comb begin
        wr_acc      = wr_en && !full;
        rd_acc      = rd_en && !empty;
        wr_ptr_d    = wr_acc ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d    = rd_acc ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d     = count_q + CW'(wr_acc) - CW'(rd_acc);
        overflow_d  = (wr_en && full) || (overflow_q && !clr_err);
        underflow_d = (rd_en && empty) || (underflow_q && !clr_err);
    end

    // Control state, discarded immediately on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately not reset
    always_ff @(posedge clk) begin
        if (wr_acc) mem_q[wr_ptr_q] <= wr_data;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign rd_data  = empty ? '0 : mem_q[rd_ptr_q];
            assign rd_valid = !empty;
        end else begin : g_std
            logic [DATA_W-1:0] rd_data_q, rd_data_d;
            logic              rd_valid_q, rd_valid_d;
            // Registered read port: load on accepted read, otherwise hold
            always_comb begin
                rd_data_d  = rd_acc ? mem_q[rd_ptr_q] : rd_data_q;
                rd_valid_d = rd_acc;
            end
            // Read output register
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rd_data_q  <= '0;
                    rd_valid_q <= 1'b0;
                end else begin
                    rd_data_q  <= rd_data_d;
                    rd_valid_q <= rd_valid_d;
                end
            end
            assign rd_data  = rd_data_q;
            assign rd_valid = rd_valid_q;
        end
    endgenerate
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: standard and FWFT FIFOs driven in lockstep and checked against a queue model
module tb_sync_fifo_param;
    localparam int DW = 8;
    localparam int DEPTH = 16;

    logic          clk = 0, rst = 1, wr_en = 0, rd_en = 0, clr_err = 0;
    logic [DW-1:0] wr_data = '0;
    logic [DW-1:0] rd_data, rd_data_f;
    logic          rd_valid, rd_valid_f;
    logic [4:0]    count, count_f;
    logic          full, empty, almost_full, almost_empty, overflow, underflow;
    logic          full_f, empty_f, af_f, ae_f, ovf_f, unf_f;

    int errors = 0, checks = 0;

    logic [DW-1:0] q[$];
    logic [DW-1:0] exp_rd = '0;
    logic          exp_rv = 0, exp_ovf = 0, exp_unf = 0;

    always #5 clk = ~clk;

    sync_fifo_param #(.DATA_W(DW), .DEPTH(DEPTH), .AF_THRESH(12), .AE_THRESH(2), .FWFT(0)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(rd_data), .rd_valid(rd_valid), .count(count), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .overflow(overflow),
        .underflow(underflow), .clr_err(clr_err));

    sync_fifo_param #(.DATA_W(DW), .DEPTH(DEPTH), .AF_THRESH(12), .AE_THRESH(2), .FWFT(1)) dut_f (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(rd_data_f), .rd_valid(rd_valid_f), .count(count_f), .full(full_f), .empty(empty_f),
        .almost_full(af_f), .almost_empty(ae_f), .overflow(ovf_f),
        .underflow(unf_f), .clr_err(clr_err));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        int n = q.size();
        chk("count", 32'(count), 32'(n));
        chk("full", 32'(full), 32'(n == DEPTH));
        chk("empty", 32'(empty), 32'(n == 0));
        chk("almost_full", 32'(almost_full), 32'(n >= 12));
        chk("almost_empty", 32'(almost_empty), 32'(n <= 2));
        chk("overflow", 32'(overflow), 32'(exp_ovf));
        chk("underflow", 32'(underflow), 32'(exp_unf));
        chk("rd_valid", 32'(rd_valid), 32'(exp_rv));
        chk("rd_data", 32'(rd_data), 32'(exp_rd));
        chk("f_count", 32'(count_f), 32'(n));
        chk("f_flags", {26'd0, full_f, empty_f, af_f, ae_f, ovf_f, unf_f},
            {26'd0, n == DEPTH, n == 0, n >= 12, n <= 2, exp_ovf, exp_unf});
        chk("f_rd_valid", 32'(rd_valid_f), 32'(n != 0));
        if (n != 0) chk("f_rd_data", 32'(rd_data_f), 32'(q[0]));
    endtask

    task automatic step(input logic w, input logic [DW-1:0] d, input logic r, input logic c);
        int n = q.size();
        wr_en = w; wr_data = d; rd_en = r; clr_err = c;
        exp_ovf = (w && n == DEPTH) || (exp_ovf && !c);
        exp_unf = (r && n == 0) || (exp_unf && !c);
        exp_rv = r && n != 0;
        if (exp_rv) exp_rd = q.pop_front();
        if (w && n != DEPTH) q.push_back(d);
        @(posedge clk);
        #1;
        wr_en = 0; rd_en = 0; clr_err = 0;
        check_all();
    endtask

    task automatic model_reset();
        q.delete();
        exp_rd = '0; exp_rv = 0; exp_ovf = 0; exp_unf = 0;
    endtask

    initial begin
        #12;
        model_reset();
        check_all();
        rst = 0;
        for (int i = 0; i < 16; i++) step(1, DW'(i), 0, 0);
        step(1, 8'hAA, 0, 0);
        for (int i = 0; i < 16; i++) step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        step(0, 0, 0, 1);
        for (int i = 0; i < 5; i++) step(1, DW'($urandom), 0, 0);
        for (int i = 0; i < 10; i++) step(1, DW'($urandom), 1, 0);
        while (q.size() < DEPTH) step(1, DW'($urandom), 0, 0);
        step(1, DW'($urandom), 1, 0);
        while (q.size() > 0) step(0, 0, 1, 0);
        step(1, 8'h3C, 1, 0);
        step(0, 0, 1, 1);
        for (int i = 0; i < 40; i++) step(1, DW'($urandom), 1, 0);
        for (int i = 0; i < 600; i++)
            step(1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0);
        while (q.size() > 0) step(0, 0, 1, 0);
        step(1, 8'h5A, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        for (int i = 0; i < 7; i++) step(1, DW'(8'h70 + i), 0, 0);
        step(1, 8'hEE, 0, 0);
        step(1, 8'hEF, 0, 0);
        #2 rst = 1;
        #1;
        model_reset();
        check_all();
        @(negedge clk) rst = 0;
        step(1, 8'hC3, 0, 0);
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
